// File: rtl/riscv_mem_arbiter_pkg.sv
// Shared constants for the IF/MEM memory-bus arbiter: state encodings,
// timer width and the words returned when an access times out.
package riscv_mem_arbiter_pkg;

  localparam int unsigned ARB_DW = 32;
  localparam int unsigned ARB_TW = 8;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_IF   = 2'd1;
  localparam logic [1:0] ARB_D    = 2'd2;

  localparam logic [31:0] ARB_IF_ERR_WORD = 32'h0000_0013;
  localparam logic [31:0] ARB_D_ERR_WORD  = 32'h0000_0000;

endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// Fetch, load/store and memory-bus signals of the arbiter; the slave view
// belongs to the arbiter, the master view to the core/memory side.
interface riscv_mem_arbiter_if #(
  parameter int unsigned DW = 32
);
  logic          if_req_i;
  logic [DW-1:0] if_addr_i;
  logic [DW-1:0] if_data_o;
  logic          if_ack_o;
  logic          d_rd_i;
  logic          d_wr_i;
  logic [DW-1:0] d_addr_i;
  logic [DW-1:0] d_wdata_i;
  logic [DW-1:0] d_rdata_o;
  logic          d_ack_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [DW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;
  logic          mem_ack_i;
  logic          if_stall_o;
  logic          d_stall_o;
  logic          err_o;

  modport slave (
    input  if_req_i, if_addr_i, d_rd_i, d_wr_i, d_addr_i, d_wdata_i,
           mem_rdata_i, mem_ack_i,
    output if_data_o, if_ack_o, d_rdata_o, d_ack_o, mem_req_o, mem_we_o,
           mem_addr_o, mem_wdata_o, if_stall_o, d_stall_o, err_o
  );

  modport master (
    output if_req_i, if_addr_i, d_rd_i, d_wr_i, d_addr_i, d_wdata_i,
           mem_rdata_i, mem_ack_i,
    input  if_data_o, if_ack_o, d_rdata_o, d_ack_o, mem_req_o, mem_we_o,
           mem_addr_o, mem_wdata_o, if_stall_o, d_stall_o, err_o
  );
endinterface

// File: rtl/riscv_mem_arbiter_timer.sv
// Access watchdog: cleared on grant, counts ack-less cycles, flags TIMEOUT.
module riscv_arb_timer
  import riscv_mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_clr,
  input  logic i_en,
  output logic o_done
);
  localparam logic [ARB_TW-1:0] LP_LIMIT = ARB_TW'(TIMEOUT);

  logic [ARB_TW-1:0] r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_done = (r_cnt == LP_LIMIT);
endmodule

// File: rtl/riscv_mem_arbiter.sv
// Single-port memory bus arbiter between IF fetch and MEM load/store,
// data first, with per-requester stalls and a timeout abort.
module riscv_mem_arbiter
  import riscv_mem_arbiter_pkg::*;
#(
  parameter int unsigned   DW          = ARB_DW,
  parameter int unsigned   TIMEOUT     = 15,
  parameter logic [DW-1:0] IF_ERR_WORD = DW'(ARB_IF_ERR_WORD),
  parameter logic [DW-1:0] D_ERR_WORD  = DW'(ARB_D_ERR_WORD)
) (
  input logic                clk_i,
  input logic                rst_i,
  riscv_mem_arbiter_if.slave bus
);
  logic [1:0]    r_state;
  logic          r_if_ack;
  logic          r_d_ack;
  logic          r_err;
  logic          r_mem_we;
  logic [DW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic [DW-1:0] r_if_data;
  logic [DW-1:0] r_d_rdata;

  logic w_d_req;
  logic w_busy;
  logic w_grant_d;
  logic w_grant_if;
  logic w_done;
  logic w_finish;

  // A requester whose ack is currently pulsing still shows its old request.
  assign w_d_req    = bus.d_rd_i | bus.d_wr_i;
  assign w_busy     = (r_state != ARB_IDLE);
  assign w_grant_d  = !w_busy && w_d_req && !r_d_ack;
  assign w_grant_if = !w_busy && !w_grant_d && bus.if_req_i && !r_if_ack;
  assign w_finish   = w_busy && (bus.mem_ack_i || w_done);

  riscv_arb_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .i_clr  (w_grant_d | w_grant_if),
    .i_en   (w_busy && !bus.mem_ack_i && !w_done),
    .o_done (w_done)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ARB_IDLE;
      r_if_ack    <= 1'b0;
      r_d_ack     <= 1'b0;
      r_err       <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_data   <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_if_ack <= 1'b0;
      r_d_ack  <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (w_grant_d) begin
            r_state     <= ARB_D;
            r_mem_addr  <= bus.d_addr_i;
            r_mem_wdata <= bus.d_wdata_i;
            r_mem_we    <= bus.d_wr_i;
          end else if (w_grant_if) begin
            r_state    <= ARB_IF;
            r_mem_addr <= bus.if_addr_i;
            r_mem_we   <= 1'b0;
          end
        end
        ARB_IF: begin
          if (w_finish) begin
            r_state   <= ARB_IDLE;
            r_if_ack  <= 1'b1;
            r_if_data <= bus.mem_ack_i ? bus.mem_rdata_i : IF_ERR_WORD;
            if (!bus.mem_ack_i) r_err <= 1'b1;
          end
        end
        ARB_D: begin
          if (w_finish) begin
            r_state <= ARB_IDLE;
            r_d_ack <= 1'b1;
            if (!r_mem_we) r_d_rdata <= bus.mem_ack_i ? bus.mem_rdata_i : D_ERR_WORD;
            if (!bus.mem_ack_i) r_err <= 1'b1;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  // The request drops in the timeout cycle itself; a late ack there still wins.
  assign bus.mem_req_o   = w_busy && !w_done;
  assign bus.mem_we_o    = r_mem_we;
  assign bus.mem_addr_o  = r_mem_addr;
  assign bus.mem_wdata_o = r_mem_wdata;
  assign bus.if_data_o   = r_if_data;
  assign bus.if_ack_o    = r_if_ack;
  assign bus.d_rdata_o   = r_d_rdata;
  assign bus.d_ack_o     = r_d_ack;
  assign bus.err_o       = r_err;
  assign bus.if_stall_o  = bus.if_req_i & ~r_if_ack;
  assign bus.d_stall_o   = w_d_req & ~r_d_ack;
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter with a wait-state memory responder.
module tb_riscv_mem_arbiter;
  logic clk;
  logic rst;

  riscv_mem_arbiter_if #(.DW(32)) bus ();

  riscv_mem_arbiter #(
    .DW      (32),
    .TIMEOUT (15)
  ) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_tot = 0;
  int n_bad = 0;

  int mem_wait = 0;
  bit mem_mute = 0;
  bit mem_stray = 0;
  int mem_cnt = 0;
  int n_acc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] mem_lookup(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h0050_0093;
      32'h0000_0104: return 32'h00a0_0113;
      32'h0000_2000: return 32'h1234_5678;
      default:       return 32'hCAFE_F00D;
    endcase
  endfunction

  // Memory model: acks mem_wait cycles after the request rises; it keeps
  // counting through a cycle where the arbiter has just dropped the request.
  initial begin
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_ack_i = 1'b0;
      if (mem_stray) begin
        bus.mem_ack_i = 1'b1;
      end else if (!mem_mute && (bus.mem_req_o || mem_cnt != 0) && mem_cnt == mem_wait) begin
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = mem_lookup(bus.mem_addr_o);
        n_acc++;
        mem_cnt = 0;
      end else if (bus.mem_req_o) begin
        mem_cnt++;
      end else begin
        mem_cnt = 0;
      end
    end
  end

  initial begin
    int cyc, nreq, nstall, acc0, dc, ic;
    bit ok, seen;

    rst = 1'b1;
    bus.if_req_i  = 1'b0;
    bus.if_addr_i = '0;
    bus.d_rd_i    = 1'b0;
    bus.d_wr_i    = 1'b0;
    bus.d_addr_i  = '0;
    bus.d_wdata_i = '0;
    repeat (3) tick();
    check("rst_mem_req", bus.mem_req_o, 0);
    check("rst_mem_we", bus.mem_we_o, 0);
    check("rst_mem_addr", bus.mem_addr_o, 0);
    check("rst_if_ack", bus.if_ack_o, 0);
    check("rst_d_ack", bus.d_ack_o, 0);
    check("rst_if_data", bus.if_data_o, 0);
    check("rst_d_rdata", bus.d_rdata_o, 0);
    check("rst_err", bus.err_o, 0);
    rst = 1'b0;
    tick();

    // Zero-wait fetch
    bus.if_addr_i = 32'h100;
    bus.if_req_i  = 1'b1;
    mem_wait = 0;
    acc0 = n_acc;
    #1;
    nstall = bus.if_stall_o ? 1 : 0;
    cyc = 0;
    nreq = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (bus.mem_req_o) nreq++;
      if (bus.if_stall_o) nstall++;
      if (bus.if_ack_o) begin
        cyc = k;
        break;
      end
    end
    check("if_ack_cycle", cyc, 2);
    check("if_req_cycles", nreq, 1);
    check("if_stall_cycles", nstall, 2);
    check("if_data", bus.if_data_o, 32'h0050_0093);
    check("if_bus_accesses", n_acc - acc0, 1);
    tick();
    check("if_ack_pulse", bus.if_ack_o, 0);
    check("if_regrant_block", bus.mem_req_o, 0);
    bus.if_req_i = 1'b0;
    tick();

    // Simultaneous fetch and load, 2 wait states on the load
    bus.if_addr_i = 32'h104;
    bus.if_req_i  = 1'b1;
    bus.d_addr_i  = 32'h2000;
    bus.d_rd_i    = 1'b1;
    mem_wait = 2;
    acc0 = n_acc;
    dc = 0;
    ic = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1) begin
        check("pri_first_addr", bus.mem_addr_o, 32'h2000);
        check("pri_first_we", bus.mem_we_o, 0);
      end
      if (k == 5) check("pri_second_addr", bus.mem_addr_o, 32'h104);
      if (bus.d_ack_o && dc == 0) begin
        dc = k;
        bus.d_rd_i = 1'b0;
        mem_wait = 0;
      end
      if (bus.if_ack_o && ic == 0) begin
        ic = k;
        bus.if_req_i = 1'b0;
      end
      if (dc != 0 && ic != 0) break;
    end
    check("pri_d_ack_cycle", dc, 4);
    check("pri_if_ack_cycle", ic, 6);
    check("pri_d_rdata", bus.d_rdata_o, 32'h1234_5678);
    check("pri_if_data", bus.if_data_o, 32'h00a0_0113);
    check("pri_bus_accesses", n_acc - acc0, 2);
    tick();

    // Store with 3 wait states
    bus.d_addr_i  = 32'h2004;
    bus.d_wdata_i = 32'hDEAD_BEEF;
    bus.d_wr_i    = 1'b1;
    mem_wait = 3;
    ok = 1'b1;
    dc = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus.mem_req_o && (bus.mem_we_o !== 1'b1 || bus.mem_wdata_o !== 32'hDEAD_BEEF ||
                            bus.mem_addr_o !== 32'h2004)) ok = 1'b0;
      if (k == 2) check("st_d_stall_busy", bus.d_stall_o, 1);
      if (bus.d_ack_o) begin
        dc = k;
        check("st_d_stall_ack", bus.d_stall_o, 0);
        bus.d_wr_i = 1'b0;
        break;
      end
    end
    check("st_bus_stable", ok, 1);
    check("st_ack_cycle", dc, 5);
    check("st_rdata_keep", bus.d_rdata_o, 32'h1234_5678);
    tick();

    // Load and store together behave as a store
    bus.d_addr_i  = 32'h2008;
    bus.d_wdata_i = 32'h0BAD_F00D;
    bus.d_rd_i    = 1'b1;
    bus.d_wr_i    = 1'b1;
    mem_wait = 0;
    tick();
    check("rdwr_we", bus.mem_we_o, 1);
    check("rdwr_wdata", bus.mem_wdata_o, 32'h0BAD_F00D);
    tick();
    check("rdwr_ack", bus.d_ack_o, 1);
    check("rdwr_rdata_keep", bus.d_rdata_o, 32'h1234_5678);
    bus.d_rd_i = 1'b0;
    bus.d_wr_i = 1'b0;
    tick();

    // Stray acks while idle
    mem_stray = 1'b1;
    repeat (3) tick();
    mem_stray = 1'b0;
    tick();
    check("idle_ack_if", bus.if_ack_o, 0);
    check("idle_ack_d", bus.d_ack_o, 0);
    check("idle_mem_req", bus.mem_req_o, 0);
    check("idle_if_data", bus.if_data_o, 32'h00a0_0113);

    // Fetch that is never acknowledged
    mem_mute = 1'b1;
    bus.if_addr_i = 32'h200;
    bus.if_req_i  = 1'b1;
    ic = 0;
    nreq = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus.mem_req_o) nreq++;
      if (k == 16) check("to_err_before", bus.err_o, 0);
      if (bus.if_ack_o) begin
        ic = k;
        bus.if_req_i = 1'b0;
        break;
      end
    end
    check("to_ack_cycle", ic, 17);
    check("to_req_cycles", nreq, 15);
    check("to_if_data", bus.if_data_o, 32'h0000_0013);
    check("to_err", bus.err_o, 1);
    mem_mute = 1'b0;
    repeat (3) tick();
    check("to_err_sticky", bus.err_o, 1);
    check("to_data_held", bus.if_data_o, 32'h0000_0013);

    rst = 1'b1;
    tick();
    check("rst2_err_clear", bus.err_o, 0);
    check("rst2_if_data", bus.if_data_o, 0);
    rst = 1'b0;
    tick();

    // Ack lands on the timeout cycle itself
    mem_wait = 15;
    bus.if_addr_i = 32'h100;
    bus.if_req_i  = 1'b1;
    ic = 0;
    nreq = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus.mem_req_o) nreq++;
      if (bus.if_ack_o) begin
        ic = k;
        bus.if_req_i = 1'b0;
        break;
      end
    end
    check("late_ack_cycle", ic, 17);
    check("late_req_cycles", nreq, 15);
    check("late_if_data", bus.if_data_o, 32'h0050_0093);
    check("late_err", bus.err_o, 0);
    tick();

    // Reset in the middle of a load
    mem_mute = 1'b1;
    bus.d_addr_i = 32'h2000;
    bus.d_rd_i   = 1'b1;
    repeat (3) tick();
    check("mid_rst_pre_req", bus.mem_req_o, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_async_drop", bus.mem_req_o, 0);
    seen = 1'b0;
    repeat (2) begin
      tick();
      if (bus.d_ack_o) seen = 1'b1;
    end
    check("mid_rst_no_ack", seen, 0);
    bus.d_rd_i = 1'b0;
    mem_mute = 1'b0;
    mem_wait = 1;
    rst = 1'b0;
    tick();
    bus.d_rd_i = 1'b1;
    dc = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus.d_ack_o) begin
        dc = k;
        bus.d_rd_i = 1'b0;
        break;
      end
    end
    check("post_rst_ack_cycle", dc, 3);
    check("post_rst_rdata", bus.d_rdata_o, 32'h1234_5678);
    tick();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
